hht_row_mac: RTL
================

HHT_ROW_MAC -- requirements
Module: hht_row_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of data, row-length and result words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, at least 2).
REQ-003 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rlen_valid, input, 1, row length offered by the upstream control block.
REQ-006 SHALL have port rlen, input, DATA_W, number of non-zeros in the row.
REQ-007 SHALL have port rlen_ready, output, 1, row length accepted when rlen_valid and rlen_ready are both high.
REQ-008 SHALL have port pair_valid, input, 1, operand pair offered by the upstream control block.
REQ-009 SHALL have port mval, input, DATA_W, matrix value (dataIn1 side).
REQ-010 SHALL have port vval, input, DATA_W, gathered vector value (dataIn2 side).
REQ-011 SHALL have port pair_ready, output, 1, pair accepted when pair_valid and pair_ready are both high.
REQ-012 SHALL have port res_valid, output, 1, result FIFO not empty.
REQ-013 SHALL have port res_data, output, DATA_W, FIFO head: the row dot product.
REQ-014 SHALL have port res_ready, input, 1, CPU pop; pops when res_valid and res_ready are both high.
REQ-015 SHALL have port rows_done, output, 16, count of rows written to the FIFO; wraps at 2^16.
REQ-016 SHALL have port ovf, output, 1, sticky accumulate-saturation flag.

Function
REQ-017 SHALL implement FSM states IDLE, ACC and PUSH.
- IDLE: rlen_ready=1, pair_ready=0.
- ACC: rlen_ready=0, pair_ready=1.
- PUSH: both ready signals 0.
REQ-018 SHALL on rlen handshake in IDLE latch rlen into remaining count and clear the accumulator.
- Next state ACC if rlen is non-zero.
- Next state PUSH if rlen is 0, so a zero-length row yields result 0.
REQ-019 SHALL on each pair handshake in ACC add mval*vval (low DATA_W product bits) to the accumulator at that edge and decrement the remaining count.
REQ-020 SHALL go from ACC to PUSH on the edge that accepts the pair taking remaining count from 1 to 0; with no pair_valid, ACC holds and nothing changes.
REQ-021 SHALL in PUSH, when the FIFO is not full, write the accumulator at the edge, increment rows_done and return to IDLE.
REQ-022 SHALL hold PUSH while the FIFO is full; a same-cycle pop does not bypass, so the write occurs on the following edge.
REQ-023 SHALL assert res_valid in the cycle after the write edge; a push with no pop makes the FIFO count +1.
REQ-024 SHALL treat a simultaneous pop and push on a non-full, non-empty FIFO as leaving the count unchanged.
REQ-025 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH and keep res_data stable while res_valid is high and res_ready is low.
REQ-026 SHALL ignore pop requests when the FIFO is empty; the state stays unchanged.
REQ-027 SHALL ignore pair_valid in IDLE and PUSH, and rlen_valid in ACC and PUSH; no data is lost because ready is low.
REQ-028 SHALL give result latency from last pair accepted to res_valid high of 2 cycles when the FIFO is not full.

Reset
REQ-029 SHALL on Rst low, immediately and regardless of clock:
- set state IDLE;
- clear accumulator, remaining count, FIFO pointers, FIFO count, rows_done and ovf;
- drive res_valid=0, rlen_ready=0 and pair_ready=0.
REQ-030 SHALL set rlen_ready=1 from the first rising edge after Rst goes high.
REQ-031 SHALL discard any partial row in progress when Rst is asserted mid-row; FIFO contents are lost and no result is produced.

Configuration
REQ-032 SHALL support macro HHT_ROW_MAC_SAT_EN.
- Defined: each accumulate is unsigned-saturating; a sum or product beyond 2^DATA_W-1 clamps to all-ones and sets ovf sticky until reset.
- Undefined: accumulate wraps modulo 2^DATA_W and ovf is tied to 0.

Verification
REQ-033 SHALL test a basic row: rlen=3, pairs (15,7),(2,93),(11,68) -> res_data=1039, res_valid 2 cycles after the last pair, rows_done=1.
REQ-034 SHALL test a zero-length row: rlen=0 -> res_data=0, no pair accepted, rows_done increments.
REQ-035 SHALL test FIFO full: five 1-element rows (1,1) with res_ready=0.
- Expect 4 results of 1 and the FSM stuck in PUSH with rlen_ready=0.
- One pop -> the fifth result is written on the following edge.
REQ-036 SHALL test pair_valid gaps: rlen=2, pairs (3,4) then 5 idle cycles then (2,5) -> res_data=22.
REQ-037 SHALL test reset mid-row: rlen=4, two pairs, Rst pulsed low -> res_valid=0 and rows_done=0; a new row rlen=1 with (6,6) -> 36.
REQ-038 SHALL test overflow: rlen=2, pairs (0xFFFFFFFF,1),(1,1).
- With HHT_ROW_MAC_SAT_EN: res_data=0xFFFFFFFF, ovf=1.
- Without it: res_data=0, ovf=0.

Source files
------------

// File: rtl/hht_row_mac_if.sv
// rtl/hht_row_mac_if.sv - row-length, operand-pair and result channels of hht_row_mac
interface hht_row_mac_if #(
    parameter int DATA_W = 32
) ();
    logic              rlen_valid;
    logic [DATA_W-1:0] rlen;
    logic              rlen_ready;
    logic              pair_valid;
    logic [DATA_W-1:0] mval;
    logic [DATA_W-1:0] vval;
    logic              pair_ready;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic [15:0]       rows_done;
    logic              ovf;

    modport master (
        output rlen_valid, rlen, pair_valid, mval, vval, res_ready,
        input  rlen_ready, pair_ready, res_valid, res_data, rows_done, ovf
    );

    modport slave (
        input  rlen_valid, rlen, pair_valid, mval, vval, res_ready,
        output rlen_ready, pair_ready, res_valid, res_data, rows_done, ovf
    );
endinterface

// File: rtl/hht_row_mac.sv
// rtl/hht_row_mac.sv - sparse row dot-product MAC with result FIFO
// Optional HHT_ROW_MAC_SAT_EN: unsigned-saturating accumulate with sticky ovf.
module hht_row_mac #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    hht_row_mac_if.slave    bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACC, PUSH} state_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              rlen_ready_q;
    logic              pair_ready_q;
    logic [15:0]       rows_done_q;
    logic              full;
    logic              push;
    logic              pop;
    logic              rlen_hs;
    logic              pair_hs;

    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign push    = (state == PUSH) && !full;
    assign pop     = bus.res_ready && (count != '0);
    assign rlen_hs = bus.rlen_valid && rlen_ready_q;
    assign pair_hs = bus.pair_valid && pair_ready_q;

`ifdef HHT_ROW_MAC_SAT_EN
    logic [2*DATA_W-1:0] prod_full;
    logic [DATA_W-1:0]   prod_sat;
    logic [DATA_W:0]     sum;
    logic                sat_hit;
    logic                ovf_q;

    always_comb begin
        prod_full = bus.mval * bus.vval;
        prod_sat  = (|prod_full[2*DATA_W-1:DATA_W]) ? '1 : prod_full[DATA_W-1:0];
        sum       = {1'b0, acc} + {1'b0, prod_sat};
        sat_hit   = (|prod_full[2*DATA_W-1:DATA_W]) || sum[DATA_W];
        acc_next  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            ovf_q <= 1'b0;
        else if (state == ACC && pair_hs && sat_hit)
            ovf_q <= 1'b1;
    end
    assign bus.ovf = ovf_q;
`else
    logic [DATA_W-1:0] prod_lo;

    always_comb begin
        prod_lo  = bus.mval * bus.vval;
        acc_next = acc + prod_lo;
    end
    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            acc          <= '0;
            rem          <= '0;
            rlen_ready_q <= 1'b0;
            pair_ready_q <= 1'b0;
            rows_done_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // rlen_ready is registered, so it first rises on the edge after reset release
                    if (rlen_hs) begin
                        acc          <= '0;
                        rem          <= bus.rlen;
                        rlen_ready_q <= 1'b0;
                        if (bus.rlen == '0) begin
                            state        <= PUSH;
                            pair_ready_q <= 1'b0;
                        end else begin
                            state        <= ACC;
                            pair_ready_q <= 1'b1;
                        end
                    end else begin
                        rlen_ready_q <= 1'b1;
                    end
                end
                ACC: begin
                    if (pair_hs) begin
                        acc <= acc_next;
                        rem <= rem - DATA_W'(1);
                        if (rem == DATA_W'(1)) begin
                            state        <= PUSH;
                            pair_ready_q <= 1'b0;
                        end
                    end
                end
                PUSH: begin
                    if (!full) begin
                        state        <= IDLE;
                        rlen_ready_q <= 1'b1;
                        rows_done_q  <= rows_done_q + 16'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    rlen_ready_q <= 1'b0;
                    pair_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= acc;
    end

    assign bus.rlen_ready = rlen_ready_q;
    assign bus.pair_ready = pair_ready_q;
    assign bus.res_valid  = (count != '0);
    assign bus.res_data   = mem[rd_ptr];
    assign bus.rows_done  = rows_done_q;
endmodule
